// File: rtl/sc_life_event_ctrl_pkg.sv
// Shared definitions for the life event controller and its life counter.
package sc_life_event_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StOver,
        StClear,
        StGrace,
        StPlay,
        StHit,
        StCheck,
        StBonus
    } lifeState_e;

    // Commands on the counter's upcount input
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_IDLE = 2'b11;

    // Value the counter loads while clear is low
    localparam int unsigned LIFE_CLEAR_VALUE = 3;

    typedef struct packed {
        logic [1:0] upcount;
        logic       clear;     // active-low
        logic       gameover;
        logic       grace;
    } lifeOutputs_t;

    // Moore output decode: every output is a pure function of the state
    function automatic lifeOutputs_t decodeOutputs(lifeState_e st);
        lifeOutputs_t o;
        o.upcount  = CMD_IDLE;
        o.clear    = 1'b1;
        o.gameover = 1'b0;
        o.grace    = 1'b0;
        case (st)
            StOver:  o.gameover = 1'b1;
            StClear: o.clear    = 1'b0;
            StGrace: o.grace    = 1'b1;
            StHit:   o.upcount  = CMD_DEC;
            StBonus: o.upcount  = CMD_INC;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sc_life_event_ctrl_grace_timer.sv
// Post-respawn invulnerability timer: load arms it, done marks the final grace cycle.
module sc_life_grace_timer #(
    parameter int unsigned GRACE_CYCLES = 50_000_000
) (
    input  logic SC_upLIFECOUNTER_CLOCK_50,
    input  logic SC_upLIFECOUNTER_RESET_InHigh,
    input  logic load_InHigh,
    output logic done_OutHigh
);

    localparam int unsigned CntW = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;

    logic [CntW-1:0] graceCount;

    // Load on request, then count down and hold at zero
    always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
        if (SC_upLIFECOUNTER_RESET_InHigh) begin
            graceCount <= '0;
        end else if (load_InHigh) begin
            graceCount <= CntW'(GRACE_CYCLES);
        end else if (graceCount != '0) begin
            graceCount <= graceCount - CntW'(1);
        end
    end

    // The count reads 1 during the last grace cycle, so the FSM leaves exactly on time
    assign done_OutHigh = (graceCount <= CntW'(1));

endmodule

// File: rtl/sc_life_event_ctrl.sv
// Life event controller: turns collision/home events and new-game requests into
// single-cycle commands for the life counter, with a grace window after each respawn.
module sc_life_event_ctrl
    import sc_life_event_ctrl_pkg::*;
#(
    parameter int unsigned LIFE_DATAWIDTH = 8,
    parameter int unsigned MAX_LIVES      = 7,
    parameter int unsigned GRACE_CYCLES   = 50_000_000
) (
    input  logic                      SC_upLIFECOUNTER_CLOCK_50,
    input  logic                      SC_upLIFECOUNTER_RESET_InHigh,
    input  logic                      collision_InHigh,
    input  logic                      home_InHigh,
    input  logic                      newgame_InLow,
    input  logic [LIFE_DATAWIDTH-1:0] lives_InBUS,
    output logic [1:0]                upcount_OutBUS,
    output logic                      clear_OutLow,
    output logic                      gameover_OutHigh,
    output logic                      grace_OutHigh
);

    lifeState_e   state;
    lifeState_e   stateNext;
    lifeOutputs_t outs;

    logic collisionPrev;
    logic homePrev;
    logic collisionEdge;
    logic homeEdge;
    logic graceLoad;
    logic graceDone;
    logic livesZero;
    logic livesBelowMax;

    // One-cycle copies of the event levels for rising-edge detection
    always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
        if (SC_upLIFECOUNTER_RESET_InHigh) begin
            collisionPrev <= 1'b0;
            homePrev      <= 1'b0;
        end else begin
            collisionPrev <= collision_InHigh;
            homePrev      <= home_InHigh;
        end
    end

    assign collisionEdge = collision_InHigh & ~collisionPrev;
    assign homeEdge      = home_InHigh & ~homePrev;
    assign livesZero     = (lives_InBUS == '0);
    assign livesBelowMax = (lives_InBUS < LIFE_DATAWIDTH'(MAX_LIVES));

    // Next-state selection; a new-game request overrides everything except CLEAR
    always_comb begin
        stateNext = state;
        case (state)
            StOver: begin
                if (!newgame_InLow) stateNext = StClear;
            end
            StClear: begin
                stateNext = StGrace;
            end
            StGrace: begin
                if (!newgame_InLow)  stateNext = StClear;
                else if (graceDone)  stateNext = StPlay;
            end
            StPlay: begin
                // Zero lives while playing can only come from outside; end the game
                // rather than decrementing past zero
                if (!newgame_InLow)                  stateNext = StClear;
                else if (livesZero)                  stateNext = StOver;
                else if (collisionEdge)              stateNext = StHit;
                else if (homeEdge && livesBelowMax)  stateNext = StBonus;
            end
            StHit: begin
                if (!newgame_InLow) stateNext = StClear;
                else                stateNext = StCheck;
            end
            StCheck: begin
                if (!newgame_InLow) stateNext = StClear;
                else if (livesZero) stateNext = StOver;
                else                stateNext = StGrace;
            end
            StBonus: begin
                if (!newgame_InLow) stateNext = StClear;
                else                stateNext = StPlay;
            end
            default: stateNext = StOver;
        endcase
    end

    // Arm the grace timer on every entry into GRACE
    assign graceLoad = (stateNext == StGrace) && (state != StGrace);

    // State register with outputs registered alongside it from the next state
    always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
        if (SC_upLIFECOUNTER_RESET_InHigh) begin
            state <= StOver;
            outs  <= decodeOutputs(StOver);
        end else begin
            state <= stateNext;
            outs  <= decodeOutputs(stateNext);
        end
    end

    sc_life_grace_timer #(
        .GRACE_CYCLES (GRACE_CYCLES)
    ) u_grace_timer (
        .SC_upLIFECOUNTER_CLOCK_50     (SC_upLIFECOUNTER_CLOCK_50),
        .SC_upLIFECOUNTER_RESET_InHigh (SC_upLIFECOUNTER_RESET_InHigh),
        .load_InHigh                   (graceLoad),
        .done_OutHigh                  (graceDone)
    );

    assign upcount_OutBUS   = outs.upcount;
    assign clear_OutLow     = outs.clear;
    assign gameover_OutHigh = outs.gameover;
    assign grace_OutHigh    = outs.grace;

endmodule

// File: tb/tb_sc_life_event_ctrl.sv
// Bench for sc_life_event_ctrl paired with a behavioural life counter.
// Stimulus queues expected events; a negedge monitor pops and compares them.
module tb_sc_life_event_ctrl;
    import sc_life_event_ctrl_pkg::*;

    localparam int unsigned W    = 8;
    localparam int unsigned MAXL = 7;
    localparam int unsigned GC   = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         coll = 1'b0;
    logic         home = 1'b0;
    logic         ng = 1'b1;
    logic [W-1:0] lives;
    logic [1:0]   up;
    logic         clrN;
    logic         go;
    logic         gr;

    always #10 clk = ~clk;

    sc_life_event_ctrl #(
        .LIFE_DATAWIDTH (W),
        .MAX_LIVES      (MAXL),
        .GRACE_CYCLES   (GC)
    ) dut (
        .SC_upLIFECOUNTER_CLOCK_50     (clk),
        .SC_upLIFECOUNTER_RESET_InHigh (rst),
        .collision_InHigh              (coll),
        .home_InHigh                   (home),
        .newgame_InLow                 (ng),
        .lives_InBUS                   (lives),
        .upcount_OutBUS                (up),
        .clear_OutLow                  (clrN),
        .gameover_OutHigh              (go),
        .grace_OutHigh                 (gr)
    );

    // Behavioural life counter
    always @(posedge clk or posedge rst) begin
        if (rst)                lives <= '0;
        else if (!clrN)         lives <= W'(LIFE_CLEAR_VALUE);
        else if (up == 2'b10)   lives <= lives - 1'b1;
        else if (up == 2'b01)   lives <= lives + 1'b1;
    end

    typedef enum int {EvClear, EvDec, EvInc, EvGrace, EvOver} ev_e;
    typedef struct {
        ev_e kind;
        int  val;
    } ev_t;

    ev_t expQ[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  graceLen   = 0;
    logic prevGo    = 1'b1;

    task automatic pushExp(input ev_e k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        expQ.push_back(e);
    endtask

    task automatic observe(input ev_e k, input int v);
        ev_t e;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: got %s(%0d), required no event", k.name(), v);
        end else begin
            e = expQ.pop_front();
            if (e.kind != k || e.val != v) begin
                mismatched++;
                $display("FAIL event: got %s(%0d), required %s(%0d)",
                         k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: reports every command, grace window and game-over entry
    always @(negedge clk) begin
        if (rst) begin
            graceLen = 0;
            prevGo   = go;
        end else begin
            if (!clrN)            observe(EvClear, int'(lives));
            if (up == CMD_DEC)    observe(EvDec, int'(lives));
            if (up == CMD_INC)    observe(EvInc, int'(lives));
            if (up == 2'b00) begin
                compared++;
                mismatched++;
                $display("FAIL upcount_code: got 0, required 1, 2 or 3");
            end
            if (gr) begin
                graceLen++;
            end else if (graceLen != 0) begin
                observe(EvGrace, graceLen);
                graceLen = 0;
            end
            if (go && !prevGo) observe(EvOver, int'(lives));
            prevGo = go;
        end
    end

    task automatic newGame(input int livesBefore);
        pushExp(EvClear, livesBefore);
        pushExp(EvGrace, GC);
        @(negedge clk) ng = 1'b0;
        @(negedge clk) ng = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic hit(input int livesBefore, input bit last);
        pushExp(EvDec, livesBefore);
        if (last) pushExp(EvOver, 0);
        else      pushExp(EvGrace, GC);
        @(negedge clk) coll = 1'b1;
        @(negedge clk) coll = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic bonus(input int livesBefore, input bit expectCmd);
        if (expectCmd) pushExp(EvInc, livesBefore);
        @(negedge clk) home = 1'b1;
        @(negedge clk) home = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkVal("reset_gameover", int'(go), 1);
        checkVal("reset_grace", int'(gr), 0);
        checkVal("reset_clear", int'(clrN), 1);
        checkVal("reset_upcount", int'(up), int'(CMD_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // New game: one clear pulse, 3 lives, 4-cycle grace
        newGame(0);
        checkVal("start_lives", int'(lives), 3);
        checkVal("start_gameover", int'(go), 0);

        // Collision held high through grace and beyond: only one decrement
        pushExp(EvDec, 3);
        pushExp(EvGrace, GC);
        @(negedge clk) coll = 1'b1;
        repeat (12) @(negedge clk);
        checkVal("held_collision_lives", int'(lives), 2);
        coll = 1'b0;
        @(negedge clk);

        // Bonuses up to the ceiling, then one that must be ignored
        for (int l = 2; l < int'(MAXL); l++) bonus(l, 1'b1);
        checkVal("bonus_max_lives", int'(lives), int'(MAXL));
        bonus(int'(MAXL), 1'b0);
        checkVal("bonus_saturated_lives", int'(lives), int'(MAXL));

        // Back down to 3
        for (int l = int'(MAXL); l > 3; l--) hit(l, 1'b0);
        checkVal("down_to_three", int'(lives), 3);

        // Collision and home in the same cycle: collision wins
        pushExp(EvDec, 3);
        pushExp(EvGrace, GC);
        @(negedge clk) begin
            coll = 1'b1;
            home = 1'b1;
        end
        @(negedge clk) begin
            coll = 1'b0;
            home = 1'b0;
        end
        repeat (8) @(negedge clk);
        checkVal("simultaneous_lives", int'(lives), 2);

        // New game mid-play, then three collisions to game over
        newGame(2);
        checkVal("restart_lives", int'(lives), 3);
        hit(3, 1'b0);
        hit(2, 1'b0);
        hit(1, 1'b1);
        checkVal("over_gameover", int'(go), 1);
        checkVal("over_lives", int'(lives), 0);
        checkVal("over_grace", int'(gr), 0);

        // Events while game over do nothing
        @(negedge clk) begin
            coll = 1'b1;
            home = 1'b1;
        end
        @(negedge clk) begin
            coll = 1'b0;
            home = 1'b0;
        end
        repeat (4) @(negedge clk);
        checkVal("idle_over_lives", int'(lives), 0);
        checkVal("idle_over_gameover", int'(go), 1);

        // Asynchronous reset in the middle of HIT
        newGame(0);
        checkVal("third_game_lives", int'(lives), 3);
        pushExp(EvDec, 3);
        @(negedge clk) coll = 1'b1;
        @(negedge clk) coll = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkVal("async_rst_upcount", int'(up), int'(CMD_IDLE));
        checkVal("async_rst_gameover", int'(go), 1);
        checkVal("async_rst_grace", int'(gr), 0);
        checkVal("async_rst_clear", int'(clrN), 1);
        checkVal("async_rst_lives", int'(lives), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("post_rst_gameover", int'(go), 1);
        checkVal("pending_events", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sc_life_event_ctrl.md
SC_LIFE_EVENT_CTRL -- requirements
Module: sc_life_event_ctrl

Interface
REQ-001 SHALL have parameter LIFE_DATAWIDTH, default 8, width of lives bus (equal to life counter data width).
REQ-002 SHALL have parameter MAX_LIVES, default 7, saturation ceiling for bonus increments.
REQ-003 SHALL have parameter GRACE_CYCLES, default 50_000_000, post-respawn invulnerability length in clocks (1 s at 50 MHz).
REQ-004 SC_upLIFECOUNTER_CLOCK_50  input  1  system clock, all state on rising edge.
REQ-005 SC_upLIFECOUNTER_RESET_InHigh  input  1  reset, asynchronous, active-high.
REQ-006 collision_InHigh  input  1  level, frog overlaps hazard.
REQ-007 home_InHigh  input  1  level, frog reached a goal slot.
REQ-008 newgame_InLow  input  1  start request, active-low, synchronous.
REQ-009 lives_InBUS  input  LIFE_DATAWIDTH  current count fed back from life counter.
REQ-010 upcount_OutBUS  output  2  command to counter: 2'b10 decrement, 2'b01 increment, 2'b11 idle.
REQ-011 clear_OutLow  output  1  active-low load of counter to 3.
REQ-012 gameover_OutHigh  output  1  high while no game in progress.
REQ-013 grace_OutHigh  output  1  high during invulnerability window.

Function
REQ-014 SHALL implement Moore FSM, states OVER, CLEAR, GRACE, PLAY, HIT, CHECK, BONUS; all outputs registered/decoded from state only.
REQ-015 SHALL detect rising edges of collision_InHigh and home_InHigh against a one-cycle registered copy; levels alone never trigger.
REQ-016 OVER: gameover_OutHigh=1, upcount=2'b11, clear=1; newgame_InLow==0 -> CLEAR.
REQ-017 CLEAR: exactly one cycle, clear_OutLow=0; -> GRACE, grace timer loaded with GRACE_CYCLES.
REQ-018 GRACE: grace_OutHigh=1; collision and home edges ignored; after GRACE_CYCLES cycles -> PLAY.
REQ-019 PLAY: collision edge -> HIT; else home edge with lives_InBUS < MAX_LIVES -> BONUS; home edge at MAX_LIVES -> stay PLAY, no command.
REQ-020 PLAY with collision and home edges in same cycle: collision wins, home edge discarded.
REQ-021 PLAY with lives_InBUS==0 (external corruption) -> OVER, no decrement issued (underflow guard).
REQ-022 HIT: exactly one cycle, upcount_OutBUS=2'b10; -> CHECK.
REQ-023 CHECK: one cycle, upcount=2'b11; lives_InBUS==0 -> OVER, else -> GRACE (timer reloaded).
REQ-024 BONUS: exactly one cycle, upcount_OutBUS=2'b01; -> PLAY.
REQ-025 newgame_InLow==0 in any state other than CLEAR -> CLEAR next cycle (highest priority after reset).
REQ-026 Latency: input edge at clock N -> command state during cycle N+1 -> counter updated at clock N+2.
REQ-027 Grace counter width = $clog2(GRACE_CYCLES+1); no wrap, holds at zero.
REQ-028 At most one non-idle command per event; upcount never 2'b00.

Reset
REQ-029 Reset SHALL force state OVER, gameover_OutHigh=1, grace_OutHigh=0, clear_OutLow=1, upcount_OutBUS=2'b11, grace counter 0, edge registers 0.
REQ-030 Reset mid-HIT or mid-BONUS SHALL abort the command within the same cycle (asynchronous).

Structure
REQ-031 Shared package SHALL hold state encoding, command constants CMD_DEC=2'b10, CMD_INC=2'b01, CMD_IDLE=2'b11, and LIFE_CLEAR_VALUE=3.
REQ-032 Grace timer SHALL be sub-module sc_life_grace_timer (load, done, parameter GRACE_CYCLES).
REQ-033 Block SHALL connect point-to-point to the life counter: upcount_OutBUS->upcount input, clear_OutLow->clear input, counter output->lives_InBUS.

Verification (bench GRACE_CYCLES=4, paired with life counter)
REQ-034 Reset, newgame low 1 cycle -> one clear pulse, lives=3, grace high 4 cycles, then PLAY.
REQ-035 Collision edge in PLAY with lives=3 -> single 2'b10 cycle, lives=2 two clocks later, grace 4 cycles; collision held high throughout -> no second decrement.
REQ-036 Three collisions separated by grace -> lives=0, gameover_OutHigh=1 after third CHECK.
REQ-037 Home edge at lives=2 -> one 2'b01 cycle, lives=3; repeated to lives=7 then further home edge -> no command, lives stays 7.
REQ-038 Collision and home rising same cycle at lives=3 -> only decrement, lives=2.
REQ-039 Async reset asserted during HIT -> upcount 2'b11 immediately, state OVER, counter 0.
